// File: rtl/jet_inference_sequencer.sv
// Frame sequencer for one jet-tagging inference core: serial features in, start/done handshake, serial scores out.
// Optional macro SEQ_ARGMAX_EN adds m_class, the registered argmax of the captured scores.
module jet_inference_sequencer #(
    parameter int WIDTH          = 16,
    parameter int INPUT_SIZE     = 16,
    parameter int OUTPUT_SIZE    = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH-1:0]              s_data,
    output logic                          core_input_ready,
    output logic [WIDTH*INPUT_SIZE-1:0]   core_input_data,
    input  logic                          core_output_ready,
    input  logic [WIDTH*OUTPUT_SIZE-1:0]  core_output_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH-1:0]              m_data,
    output logic                          m_last,
`ifdef SEQ_ARGMAX_EN
    output logic [$clog2(OUTPUT_SIZE)-1:0] m_class,
`endif
    output logic                          busy,
    output logic                          timeout_err,
    output logic [CNT_W-1:0]              frame_count
);

    localparam int IN_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int OUT_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int WC_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    in_idx_q, in_idx_d;
    logic [OUT_W-1:0]   out_idx_q, out_idx_d;
    logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [WIDTH-1:0]   obuf_q [OUTPUT_SIZE];
    logic               load_en;
    logic               capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_idx_q    <= in_idx_d;
            out_idx_q   <= out_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        out_idx_d   = out_idx_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        frame_cnt_d = frame_cnt_q;
        load_en     = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = LOAD;
                    in_idx_d = '0;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    load_en = 1'b1;
                    if (in_idx_q == IN_W'(INPUT_SIZE - 1)) begin
                        state_d  = START;
                        in_idx_d = '0;
                    end else begin
                        in_idx_d = in_idx_q + IN_W'(1);
                    end
                end
            end
            START: begin
                timeout_d  = 1'b0;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
                // A done arriving on the final watchdog cycle still wins.
                if (core_output_ready) begin
                    capture   = 1'b1;
                    out_idx_d = '0;
                    state_d   = DRAIN;
                end else if (wait_cnt_q == WC_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (out_idx_q == OUT_W'(OUTPUT_SIZE - 1)) begin
                        out_idx_d   = '0;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        in_idx_d    = '0;
                        state_d     = enable ? LOAD : IDLE;
                    end else begin
                        out_idx_d = out_idx_q + OUT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Each feature slot only loads in LOAD, so the frame stays stable for the core.
    for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_feat
        logic [WIDTH-1:0] feat_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                feat_q <= '0;
            end else if (load_en && (in_idx_q == IN_W'(gi))) begin
                feat_q <= s_data;
            end
        end
        assign core_input_data[gi*WIDTH +: WIDTH] = feat_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                obuf_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                obuf_q[i] <= core_output_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign s_ready          = (state_q == LOAD);
    assign core_input_ready = (state_q == START);
    assign m_valid          = (state_q == DRAIN);
    assign m_data           = (state_q == DRAIN) ? obuf_q[out_idx_q] : '0;
    assign m_last           = (state_q == DRAIN) && (out_idx_q == OUT_W'(OUTPUT_SIZE - 1));
    assign busy             = (state_q != IDLE);
    assign timeout_err      = timeout_q;
    assign frame_count      = frame_cnt_q;

`ifdef SEQ_ARGMAX_EN
    logic [OUT_W-1:0] class_d, class_q;
    logic [WIDTH-1:0] best_val;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        class_d  = '0;
        best_val = core_output_data[WIDTH-1:0];
        for (int i = 1; i < OUTPUT_SIZE; i++) begin
            if ($signed(core_output_data[i*WIDTH +: WIDTH]) > $signed(best_val)) begin
                best_val = core_output_data[i*WIDTH +: WIDTH];
                class_d  = OUT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_q <= '0;
        end else if (capture) begin
            class_q <= class_d;
        end
    end

    assign m_class = class_q;
`else
    // Default build carries no class output.
`endif

endmodule

// File: tb/tb_jet_inference_sequencer.sv
// Scoreboard bench for jet_inference_sequencer: directed frames, a queue of expected scores and a drain monitor.
module tb_jet_inference_sequencer;

    localparam int W  = 16;
    localparam int NI = 16;
    localparam int NO = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            core_input_ready;
    logic [W*NI-1:0] core_input_data;
    logic            core_output_ready;
    logic [W*NO-1:0] core_output_data;
    logic            m_valid;
    logic            m_ready;
    logic [W-1:0]    m_data;
    logic            m_last;
    logic            busy;
    logic            timeout_err;
    logic [15:0]     frame_count;
`ifdef SEQ_ARGMAX_EN
    logic [2:0]      m_class;
`endif

    jet_inference_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .core_input_ready  (core_input_ready),
        .core_input_data   (core_input_data),
        .core_output_ready (core_output_ready),
        .core_output_data  (core_output_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_last            (m_last),
`ifdef SEQ_ARGMAX_EN
        .m_class           (m_class),
`endif
        .busy              (busy),
        .timeout_err       (timeout_err),
        .frame_count       (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic [2:0]   cls;
    } exp_t;

    typedef int scores_t [NO];

    exp_t exp_q [$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   frame_exp = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: pops one expected score per output handshake; checks hold while stalled.
    always @(negedge clk) begin
        if (!reset && m_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h, expected no output", m_data);
            end else if (m_ready) begin
                mon_e = exp_q.pop_front();
                check("m_data", m_data, mon_e.data);
                check("m_last", m_last, mon_e.last);
`ifdef SEQ_ARGMAX_EN
                check("m_class", m_class, mon_e.cls);
`endif
            end else begin
                check("m_data_hold", m_data, exp_q[0].data);
            end
        end
    end

    task automatic send_features(input int fb, input int fs, input int drop_at, input bit rnd,
                                 output logic [W*NI-1:0] frame);
        logic [W-1:0] v;
        int n;
        frame = '0;
        for (int i = 0; i < NI; i++) begin
            v = W'(fb + fs * i);
            frame[i*W +: W] = v;
            if (rnd) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = v;
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL s_ready_wait: got s_ready=0 for 100 cycles, expected 1");
            end
            @(posedge clk);
            #1;
            if (i == drop_at) enable = 1'b0;
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    // done_at: posedges after the strobe edge at which done is raised; negative means never.
    task automatic run_frame(input int fb, input int fs, input int drop_at, input bit rnd,
                             input scores_t sc, input int cls, input int done_at, input bit stall);
        logic [W*NI-1:0] frame;
        exp_t e;
        int n;
        send_features(fb, fs, drop_at, rnd, frame);
        @(negedge clk);
        check("strobe_on", core_input_ready, 1);
        check("frame_data", core_input_data, frame);
        @(negedge clk);
        check("strobe_off", core_input_ready, 0);
        check("timeout_clear", timeout_err, 0);
        if (done_at < 0) begin
            repeat (63) @(posedge clk);
            #1;
            check("wd_last_cycle_err", timeout_err, 0);
            check("wd_last_cycle_busy", busy, 1);
            @(posedge clk);
            #1;
            check("timeout_err", timeout_err, 1);
            check("busy_after_timeout", busy, 0);
            check("m_valid_after_timeout", m_valid, 0);
            check("frame_count_timeout", frame_count, frame_exp);
        end else begin
            for (int k = 0; k < NO; k++) begin
                e.data = W'(sc[k]);
                e.last = (k == NO - 1);
                e.cls  = 3'(cls);
                exp_q.push_back(e);
                core_output_data[k*W +: W] = W'(sc[k]);
            end
            repeat (done_at - 1) @(posedge clk);
            #1;
            core_output_ready = 1'b1;
            @(posedge clk);
            #1;
            core_output_ready = 1'b0;
            core_output_data  = '1;
            check("m_valid_latency", m_valid, 1);
            check("no_timeout", timeout_err, 0);
            if (stall) begin
                @(posedge clk);
                #1;
                m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
            n = 0;
            while (exp_q.size() > 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL drain_wait: got %0d scores left, expected 0", exp_q.size());
            end
            @(posedge clk);
            #1;
            frame_exp++;
            check("frame_count", frame_count, frame_exp);
            check("m_valid_after_drain", m_valid, 0);
        end
    endtask

    initial begin
        logic [W*NI-1:0] frame;
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [W*NI-1:0] frame;
        reset             = 1'b1;
        enable            = 1'b0;
        s_valid           = 1'b0;
        s_data            = '0;
        m_ready           = 1'b1;
        core_output_ready = 1'b0;
        core_output_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_core_input_data", core_input_data, 0);
        reset  = 1'b0;
        enable = 1'b1;

        run_frame(1024, 1024, -1, 1'b0, '{100, -5, 300, 7, 0}, 2, 10, 1'b0);
        run_frame(-2000, 37, -1, 1'b1, '{-1000, 2047, 12, -3, 500}, 1, 20, 1'b1);
        run_frame(5, 5, -1, 1'b0, '{1, 2, 3, 4, 5}, 4, -1, 1'b0);
        run_frame(7, -3, -1, 1'b0, '{5, 4, 3, 2, 1}, 0, 64, 1'b0);
        run_frame(300, 2, 3, 1'b0, '{-7, -8, -9, -6, -10}, 3, 15, 1'b0);
        check("idle_busy", busy, 0);
        check("idle_s_ready", s_ready, 0);

        enable = 1'b1;
        send_features(100, 1, -1, 1'b0, frame);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midwait_rst_busy", busy, 0);
        check("midwait_rst_core_input_data", core_input_data, 0);
        check("midwait_rst_frame_count", frame_count, 0);
        check("midwait_rst_strobe", core_input_ready, 0);
        check("midwait_rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        frame_exp = 0;

        run_frame(0, 1, -1, 1'b0, '{-200, 50, 50, -1, 3}, 1, 5, 1'b0);
        run_frame(11, 11, -1, 1'b1, '{-512, -512, -512, -512, -512}, 0, 3, 1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jet_inference_sequencer.md
Name: jet_inference_sequencer

Overview:
- Sequences one `waiz_benchmark` jet-tagging inference core from serial streams.
- Collects INPUT_SIZE signed fixed-point features from a valid/ready input stream and presents them as a stable parallel frame.
- Pulses the core's start strobe, waits for its done strobe under a watchdog, captures the OUTPUT_SIZE class scores and replays them on a valid/ready output stream.
- Sits between the board I/O or DMA side and the core inside the benchmark top level.

Parameters:
- WIDTH, 16: bit width of each feature and score (Q6.10 signed).
- INPUT_SIZE, 16: features per frame.
- OUTPUT_SIZE, 5: scores per frame.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort (must be ≥2).
- CNT_W, 16: width of frame_count.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new frames to start.
- s_valid  in  1  input feature valid.
- s_ready  out  1  sequencer accepts a feature.
- s_data  in  WIDTH  signed feature.
- core_input_ready  out  1  one-cycle start strobe to the core.
- core_input_data  out  WIDTH x INPUT_SIZE  frame to the core.
- core_output_ready  in  1  core done strobe.
- core_output_data  in  WIDTH x OUTPUT_SIZE  core scores.
- m_valid  out  1  output score valid.
- m_ready  in  1  downstream accepts the score.
- m_data  out  WIDTH  signed score.
- m_last  out  1  marks the final score of a frame.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag.
- frame_count  out  CNT_W  count of completed frames.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - Feature buffer, score buffer, indices, WAIT counter, frame_count, timeout_err all 0.
  - Every output is 0, including s_ready, m_valid and core_input_data.
- States: IDLE, LOAD, START, WAIT, DRAIN. Outputs are decoded from registered state and counters only; there is no combinational path from s_valid or m_ready to any output.
- IDLE:
  - s_ready=0.
  - enable=1 → LOAD with in_idx=0.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready: buf[in_idx]=s_data, in_idx++.
  - Accepting the feature with in_idx==INPUT_SIZE-1 → START.
  - enable is ignored once in LOAD; a frame in progress always completes.
- START:
  - core_input_ready=1 for exactly one cycle, on the cycle after the last feature handshake.
  - timeout_err cleared.
  - WAIT counter cleared.
  - → WAIT.
- core_input_data:
  - Always drives buf.
  - Buffer writes happen only in LOAD, so data is stable from START until the next frame's first feature.
- WAIT:
  - Counter increments each cycle.
  - core_output_ready=1 → capture core_output_data into obuf, out_idx=0, → DRAIN. Done takes priority if it coincides with the timeout cycle.
  - Otherwise, at counter==TIMEOUT_CYCLES-1 → timeout_err=1, scores discarded, frame_count unchanged, → IDLE.
  - core_output_ready is ignored in every state except WAIT.
- DRAIN:
  - m_valid=1, m_data=obuf[out_idx], m_last=(out_idx==OUTPUT_SIZE-1).
  - m_data is held until the handshake m_valid&m_ready, then out_idx++.
  - Last handshake → frame_count++ (wraps modulo 2^CNT_W).
  - After the last handshake: → LOAD with in_idx=0 if enable=1, else → IDLE.
- Latency:
  - Last input handshake → strobe: 1 cycle.
  - Done → first m_valid: 1 cycle.
  - Best-case back-to-back throughput: INPUT_SIZE + 1 + core latency + 1 + OUTPUT_SIZE cycles per frame.
- Reset asserted mid-frame: the partial frame is lost; all state returns to reset values immediately.
- Width rules: data passes through unmodified; there is no arithmetic on the data path.

Optional Feature:
- Macro: SEQ_ARGMAX_EN.
- When defined:
  - Adds output m_class, width $clog2(OUTPUT_SIZE).
  - At capture, m_class is registered as the index of the maximum signed score; ties resolve to the lowest index.
  - m_class is held constant for the whole DRAIN and reset to 0.
- When undefined: the port and its logic are absent.

Test Plan:
- Basic frame: enable=1; stream features 1..16 (×1024) with s_valid held high; core returns done 10 cycles after the strobe with scores {100,-5,300,7,0} → strobe is exactly 1 cycle; m_data sequence 100,-5,300,7,0; m_last only on 0; frame_count=1.
- Backpressure: toggle s_valid randomly and hold m_ready=0 for 5 cycles mid-drain → no feature lost or duplicated; m_data stable while stalled; order preserved.
- Timeout: core never asserts done → timeout_err=1 in cycle 64 of WAIT; state IDLE; frame_count unchanged. Next frame's START clears timeout_err.
- Done on the timeout cycle: core_output_ready=1 exactly at counter 63 → DRAIN entered, timeout_err stays 0.
- enable dropped during LOAD: frame completes and drains, then busy=0 and s_ready=0. Also assert reset mid-WAIT → all outputs 0 immediately.
- SEQ_ARGMAX_EN: scores {-200,50,50,-1,3} → m_class=1 throughout DRAIN. Scores all -512 → m_class=0.
